// File: rtl/branch_predictor_if.sv
// branch_predictor_if: lookup and update bus between the pipeline and the branch target buffer
interface branch_predictor_if;
   logic [31:0] lookup_pc;
   logic        predict_taken;
   logic [31:0] predict_target;
   logic        predict_hit;
   logic        update_valid;
   logic [31:0] update_pc;
   logic        update_taken;
   logic [31:0] update_target;
   logic        update_predicted;
   logic        ready;
   logic [15:0] mispredict_count;
   modport master (
      output lookup_pc, update_valid, update_pc, update_taken, update_target, update_predicted,
      input  predict_taken, predict_target, predict_hit, ready, mispredict_count
   );
   modport slave (
      input  lookup_pc, update_valid, update_pc, update_taken, update_target, update_predicted,
      output predict_taken, predict_target, predict_hit, ready, mispredict_count
   );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters, cleared by an init sequencer after reset
module branch_predictor #(
   parameter int INDEX_BITS = 6
) (
   input logic               clk,
   input logic               reset,
   branch_predictor_if.slave bp
);
   localparam int TAG_BITS = 30 - INDEX_BITS;
   localparam int ENTRIES  = 2 ** INDEX_BITS;
   typedef enum logic {INIT, RUN} state_t;
   state_t                state_q, state_d;
   logic [INDEX_BITS-1:0] idx_q, idx_d;
   logic                  ready_q, ready_d;
   logic [15:0]           miss_cnt_q, miss_cnt_d;
   logic                  valid_q  [ENTRIES];
   logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
   logic [31:0]           target_q [ENTRIES];
   logic [1:0]            ctr_q    [ENTRIES];
   logic                  wr_en, valid_d;
   logic [INDEX_BITS-1:0] wr_idx, l_idx, u_idx;
   logic [TAG_BITS-1:0]   tag_d, l_tag, u_tag;
   logic [31:0]           target_d;
   logic [1:0]            ctr_d, u_ctr;
   logic                  l_hit, u_hit, upd;
   logic                  unused_pc_bits;
   assign unused_pc_bits = ^{bp.lookup_pc[1:0], bp.update_pc[1:0]};
   assign l_idx = bp.lookup_pc[INDEX_BITS+1:2];
   assign l_tag = bp.lookup_pc[31:INDEX_BITS+2];
   assign u_idx = bp.update_pc[INDEX_BITS+1:2];
   assign u_tag = bp.update_pc[31:INDEX_BITS+2];
   assign u_ctr = ctr_q[u_idx];
   // lookups see only pre-update contents; nothing is forwarded from a same-cycle update
   assign l_hit = ready_q && valid_q[l_idx] && tag_q[l_idx] == l_tag;
   assign u_hit = valid_q[u_idx] && tag_q[u_idx] == u_tag;
   assign upd   = ready_q && bp.update_valid;
   assign bp.predict_hit      = l_hit;
   assign bp.predict_taken    = l_hit && ctr_q[l_idx][1];
   assign bp.predict_target   = l_hit ? target_q[l_idx] : 32'h0;
   assign bp.ready            = ready_q;
   assign bp.mispredict_count = miss_cnt_q;
   // init sequencer walks every index once; ready follows one edge after the last clear
   always_comb begin
      state_d    = (state_q == INIT && &idx_q) ? RUN : state_q;
      idx_d      = state_q == INIT ? idx_q + 1'b1 : idx_q;
      ready_d    = state_q == RUN;
      miss_cnt_d = (upd && bp.update_predicted != bp.update_taken && ~&miss_cnt_q) ? miss_cnt_q + 16'd1 : miss_cnt_q;
   end
   // single table write port: init clearing, counter/target update on hit, allocation on taken miss
   always_comb begin
      wr_en    = 1'b0;
      wr_idx   = u_idx;
      valid_d  = 1'b1;
      tag_d    = u_tag;
      target_d = bp.update_target;
      ctr_d    = 2'b10;
      if (state_q == INIT) begin
         wr_en    = 1'b1;
         wr_idx   = idx_q;
         valid_d  = 1'b0;
         tag_d    = '0;
         target_d = '0;
         ctr_d    = 2'b01;
      end else if (upd && u_hit) begin
         wr_en    = 1'b1;
         target_d = bp.update_taken ? bp.update_target : target_q[u_idx];
         ctr_d    = bp.update_taken ? (&u_ctr ? u_ctr : u_ctr + 2'd1) : (|u_ctr ? u_ctr - 2'd1 : u_ctr);
      end else if (upd && bp.update_taken) begin
         wr_en = 1'b1;
      end
   end
   // control registers: sequencer state, ready flag and mispredict counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= INIT;
         idx_q      <= '0;
         ready_q    <= 1'b0;
         miss_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         ready_q    <= ready_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end
   // table storage; contents are defined by the init sweep rather than by reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         valid_q[wr_idx]  <= valid_d;
         tag_q[wr_idx]    <= tag_d;
         target_q[wr_idx] <= target_d;
         ctr_q[wr_idx]    <= ctr_d;
      end
   end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: random and directed stimulus checked against a behavioural BTB model
module tb_branch_predictor;
   logic clk = 0;
   logic reset = 1;
   int   total = 0;
   int   bad = 0;
   branch_predictor_if bp_if ();
   branch_predictor #(.INDEX_BITS(6)) dut (.clk(clk), .reset(reset), .bp(bp_if));
   always #5 clk = ~clk;

   bit          m_valid [64];
   int unsigned m_tag   [64];
   logic [31:0] m_tgt   [64];
   int          m_ctr   [64];
   int          m_miss;
   int          since;
   int          mi;
   bit          mh;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
      end
   endtask

   // model: ready 65 edges after release, updates only once ready, table emptied by reset
   always @(posedge clk) begin
      if (reset) begin
         since = 0;
         m_miss = 0;
         foreach (m_valid[i]) m_valid[i] = 0;
      end else begin
         if (since >= 65 && bp_if.update_valid) begin
            mi = (bp_if.update_pc >> 2) % 64;
            mh = m_valid[mi] && m_tag[mi] == (bp_if.update_pc >> 8);
            if (bp_if.update_predicted != bp_if.update_taken && m_miss < 65535) m_miss++;
            if (mh) begin
               if (bp_if.update_taken) begin
                  m_ctr[mi] = m_ctr[mi] < 3 ? m_ctr[mi] + 1 : 3;
                  m_tgt[mi] = bp_if.update_target;
               end else m_ctr[mi] = m_ctr[mi] > 0 ? m_ctr[mi] - 1 : 0;
            end else if (bp_if.update_taken) begin
               m_valid[mi] = 1;
               m_tag[mi] = bp_if.update_pc >> 8;
               m_tgt[mi] = bp_if.update_target;
               m_ctr[mi] = 2;
            end
         end
         if (since < 65) since++;
      end
   end

   // compare every cycle out of reset
   always @(negedge clk) begin
      if (!reset) begin
         automatic bit rdy = since >= 65;
         automatic int li = (bp_if.lookup_pc >> 2) % 64;
         automatic bit h = rdy && m_valid[li] && m_tag[li] == (bp_if.lookup_pc >> 8);
         chk("ready", {31'b0, bp_if.ready}, {31'b0, rdy});
         chk("hit", {31'b0, bp_if.predict_hit}, {31'b0, h});
         chk("taken", {31'b0, bp_if.predict_taken}, {31'b0, h && m_ctr[li] >= 2});
         chk("target", bp_if.predict_target, h ? m_tgt[li] : 32'h0);
         chk("count", {16'b0, bp_if.mispredict_count}, m_miss);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic pred);
      bp_if.update_valid = 1;
      bp_if.update_pc = pc;
      bp_if.update_taken = tk;
      bp_if.update_target = tgt;
      bp_if.update_predicted = pred;
      tick();
      bp_if.update_valid = 0;
   endtask

   task automatic look(input logic [31:0] pc);
      bp_if.lookup_pc = pc;
      #1;
   endtask

   function automatic logic [31:0] rpc();
      return ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
   endfunction

   initial begin
      bp_if.lookup_pc = 0;
      bp_if.update_valid = 0;
      bp_if.update_pc = 0;
      bp_if.update_taken = 0;
      bp_if.update_target = 0;
      bp_if.update_predicted = 0;
      repeat (3) @(posedge clk);
      #2 reset = 0;
      for (int k = 1; k <= 64; k++) begin
         if (k == 10) begin
            bp_if.update_valid = 1;
            bp_if.update_pc = 32'h40;
            bp_if.update_taken = 1;
            bp_if.update_target = 32'h100;
         end
         tick();
         bp_if.update_valid = 0;
      end
      chk("lit_ready_init", {31'b0, bp_if.ready}, 32'd0);
      tick();
      chk("lit_ready_65", {31'b0, bp_if.ready}, 32'd1);
      look(32'h40);
      chk("lit_init_upd_ignored", {31'b0, bp_if.predict_hit}, 32'd0);
      upd(32'h40, 1, 32'h100, 0);
      look(32'h40);
      chk("lit_alloc_hit", {31'b0, bp_if.predict_hit}, 32'd1);
      chk("lit_alloc_taken", {31'b0, bp_if.predict_taken}, 32'd1);
      chk("lit_alloc_target", bp_if.predict_target, 32'h100);
      chk("lit_count1", {16'b0, bp_if.mispredict_count}, 32'd1);
      upd(32'h40, 0, 0, 0);
      upd(32'h40, 0, 0, 0);
      look(32'h40);
      chk("lit_ctr0_hit", {31'b0, bp_if.predict_hit}, 32'd1);
      chk("lit_ctr0_taken", {31'b0, bp_if.predict_taken}, 32'd0);
      upd(32'h40, 1, 32'h100, 1);
      look(32'h40);
      chk("lit_ctr1_taken", {31'b0, bp_if.predict_taken}, 32'd0);
      upd(32'h40, 1, 32'h100, 1);
      upd(32'h40, 1, 32'h100, 1);
      upd(32'h40, 1, 32'h104, 1);
      upd(32'h40, 0, 0, 1);
      look(32'h40);
      chk("lit_sat3_taken", {31'b0, bp_if.predict_taken}, 32'd1);
      chk("lit_sat3_target", bp_if.predict_target, 32'h104);
      upd(32'h140, 1, 32'h200, 1);
      look(32'h40);
      chk("lit_alias_old", {31'b0, bp_if.predict_hit}, 32'd0);
      look(32'h140);
      chk("lit_alias_new", bp_if.predict_target, 32'h200);
      upd(32'h240, 0, 32'h300, 0);
      look(32'h140);
      chk("lit_nt_miss_keep", {31'b0, bp_if.predict_hit}, 32'd1);
      look(32'h240);
      chk("lit_nt_miss_noalloc", {31'b0, bp_if.predict_hit}, 32'd0);
      bp_if.lookup_pc = 32'h80;
      bp_if.update_valid = 1;
      bp_if.update_pc = 32'h80;
      bp_if.update_taken = 1;
      bp_if.update_target = 32'h180;
      bp_if.update_predicted = 1;
      #1;
      chk("lit_same_cycle_old", {31'b0, bp_if.predict_hit}, 32'd0);
      tick();
      bp_if.update_valid = 0;
      #1;
      chk("lit_same_cycle_new", {31'b0, bp_if.predict_hit}, 32'd1);
      chk("lit_same_cycle_tgt", bp_if.predict_target, 32'h180);
      repeat (3000) begin
         bp_if.lookup_pc = rpc();
         bp_if.update_valid = $urandom_range(0, 1);
         bp_if.update_pc = rpc();
         bp_if.update_taken = $urandom_range(0, 1);
         bp_if.update_target = $urandom;
         bp_if.update_predicted = $urandom_range(0, 1);
         tick();
      end
      bp_if.update_valid = 1;
      repeat (65540) begin
         bp_if.lookup_pc = rpc();
         bp_if.update_pc = rpc();
         bp_if.update_taken = $urandom_range(0, 1);
         bp_if.update_target = $urandom;
         bp_if.update_predicted = ~bp_if.update_taken;
         tick();
      end
      bp_if.update_valid = 0;
      chk("lit_count_sat", {16'b0, bp_if.mispredict_count}, 32'hFFFF);
      reset = 1;
      tick();
      tick();
      chk("lit_reset_ready", {31'b0, bp_if.ready}, 32'd0);
      chk("lit_reset_count", {16'b0, bp_if.mispredict_count}, 32'd0);
      reset = 0;
      repeat (65) tick();
      chk("lit_reinit_ready", {31'b0, bp_if.ready}, 32'd1);
      for (int i = 0; i < 64; i++) begin
         look(32'h140 & 32'hFFFF_FF00 | (i << 2));
         chk("lit_reinit_empty", {31'b0, bp_if.predict_hit}, 32'd0);
      end
      look(32'h140);
      chk("lit_reinit_140", {31'b0, bp_if.predict_hit}, 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
